// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the slice-serial subtractor.
//   state_t    : controller states (IDLE, RUN, DONE)
//   SLICE_DEF  : default number of bits processed per clock
//   cnt_width(): width of the slice counter for a given operand/slice size
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned SLICE_DEF = 4;

  // Counter width for WIDTH/SLICE slices; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width,
                                            input int unsigned slice);
    int unsigned n_slices;
    n_slices = width / slice;
    return (n_slices > 1) ? $clog2(n_slices) : 1;
  endfunction

endpackage : serial_sub_pkg

// File: rtl/nibble_sub.sv
// nibble_sub: combinational SLICE-bit subtract slice, diff = x - y - borrow_in.
// Ports:
//   x, y          : slice operands (minuend, subtrahend)
//   borrow_in     : borrow into bit 0 of the slice
//   diff          : slice difference
//   borrow_out    : borrow out of the top bit of the slice
//   msb_borrow_in : borrow into the top bit of the slice (for signed overflow)
module nibble_sub #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             borrow_in,
  output logic [SLICE-1:0] diff,
  output logic             borrow_out,
  output logic             msb_borrow_in
);

  logic [SLICE-1:0] w_y_n;
  logic [SLICE:0]   w_sum;

  // Subtraction as x + ~y + ~borrow; carry and borrow are complements.
  assign w_y_n = ~y;
  assign w_sum = {1'b0, x} + {1'b0, w_y_n} + {{SLICE{1'b0}}, ~borrow_in};

  assign diff       = w_sum[SLICE-1:0];
  assign borrow_out = ~w_sum[SLICE];

  // Carry into the top bit recovered from its sum bit and operand bits.
  assign msb_borrow_in = ~(w_sum[SLICE-1] ^ x[SLICE-1] ^ w_y_n[SLICE-1]);

endmodule : nibble_sub

// File: rtl/serial_sub32.sv
// serial_sub32: multi-cycle slice-serial subtractor d = a - b - bin with
// valid/ready handshakes, one SLICE-bit slice per clock.
// Ports:
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid / in_ready  : operand handshake (in_ready depends on state only)
//   a, b, bin            : minuend, subtrahend, borrow-in (sampled on accept)
//   out_valid / out_ready: result handshake
//   d                    : difference modulo 2^WIDTH
//   bout                 : unsigned borrow-out (a < b + bin)
//   ovf                  : two's-complement overflow
//   zero                 : d == 0
module serial_sub32
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = cnt_width(WIDTH, SLICE);

  // Operand width must split evenly into slices.
  generate
    if ((WIDTH % SLICE) != 0) begin : g_width_check
      $error("serial_sub32: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_run;
  logic             w_last_slice;
  logic [SLICE-1:0] w_diff;
  logic             w_borrow_out;
  logic             w_msb_borrow_in;
  logic [WIDTH-1:0] w_d_next;

  // Single slice unit; operands shift down so slice k always sits at bit 0.
  nibble_sub #(
    .SLICE (SLICE)
  ) u_slice (
    .x             (r_a[SLICE-1:0]),
    .y             (r_b[SLICE-1:0]),
    .borrow_in     (r_borrow),
    .diff          (w_diff),
    .borrow_out    (w_borrow_out),
    .msb_borrow_in (w_msb_borrow_in)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    w_last_slice = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_run = 1'b1;
        if (r_k == KW'(NSLICE - 1)) begin
          w_last_slice = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Result word with the current slice merged in; untouched slices keep old bits.
  always_comb begin
    w_d_next = r_d;
    w_d_next[int'(r_k) * SLICE +: SLICE] = w_diff;
  end

  // Operand, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_borrow    <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_borrow <= bin;
        r_k      <= '0;
      end else if (w_run) begin
        r_a      <= r_a >> SLICE;
        r_b      <= r_b >> SLICE;
        r_borrow <= w_borrow_out;
        r_d      <= w_d_next;
        if (w_last_slice) begin
          r_k    <= '0;
          r_bout <= w_borrow_out;
          r_ovf  <= w_msb_borrow_in ^ w_borrow_out;
          r_zero <= (w_d_next == '0);
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
      r_out_valid <= (w_next_state == DONE);
    end
  end

  // in_ready is a pure state decode, forced low while reset is held.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule : serial_sub32
